// File: rtl/axi_master_engine_if.sv
// AXI3 master-side bus bundle for axi_master_engine.
// Holds the five AXI3 channels (AW, W, B, AR, R) with the signal names of the
// AXI3 protocol. The master modport is used by the engine, and the slave
// modport by whatever memory or interconnect sits on the far side.
// Widths: id 4, addr 32, len 4, size 3, burst 2, lock 2, cache 4, prot 3,
// data 32, strb 4, resp 2.
interface axi_master_engine_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_master_engine.sv
// Single-outstanding AXI3 master engine.
// A command (cmd_*) starts one INCR burst of 32-bit beats. For a write, the
// beats come from the wr_* stream and go out on W. For a read, the R beats are
// forwarded to the rd_* stream. Each transaction finishes with a one-cycle
// done pulse. Status is reported on done_resp, done_timeout and done_proto_err.
// These status outputs hold until the next command is accepted.
//
// Handshake rule for every channel: a transfer happens on a rising aclk edge
// where valid and ready are both 1. A valid that is driven by the engine
// stays asserted, with its payload stable, until that transfer. Pass-through
// streams (wr_* to W, R to rd_*) inherit the stability of their source.
//
// Ports:
//   aclk, arst            clock and asynchronous active-low reset
//   cmd_*                 command handshake plus write flag, address, len (beats-1) and id
//   wr_*                  write-beat source stream (data, strb)
//   rd_*                  read-beat sink stream (data, last)
//   done*                 completion pulse and status
//   state_dbg             FSM state: 0 IDLE, 1 AW, 2 W, 3 B, 4 AR, 5 R
//   axi                   AXI3 master bus
module axi_master_engine #(
  parameter int TIMEOUT = 256
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        done,
  output logic [1:0]  done_resp,
  output logic        done_timeout,
  output logic        done_proto_err,
  output logic [2:0]  state_dbg,
  axi_master_engine_if.master axi
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AW = 3'd1, S_W = 3'd2, S_B = 3'd3, S_AR = 3'd4, S_R = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     addr_q;
  logic [3:0]      len_q, id_q, beat_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            done_q, timeout_q, perr_q;
  logic [1:0]      resp_q;
  logic            cmd_hs, w_hs, r_hs, idle_expired, r_beat_err;

  assign cmd_hs       = cmd_valid && cmd_ready;
  assign w_hs         = axi.wvalid && axi.wready;
  assign r_hs         = axi.rvalid && axi.rready;
  // Before this cycle's edge, idle_cnt counts the idle cycles already spent in
  // B/R. So done rises exactly TIMEOUT cycles after the state was entered.
  assign idle_expired = (idle_cnt == TO_LAST);
  // An R beat is malformed if rlast does not match the final expected beat,
  // or if the beat carries the wrong id.
  assign r_beat_err   = (axi.rlast != (beat_cnt == len_q)) || (axi.rid != id_q);

  // Fixed burst attributes: 4-byte beats, INCR, normal access.
  assign axi.awid    = id_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.arid    = id_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.wid     = id_q;
  assign axi.wdata   = wr_data;
  assign axi.wstrb   = wr_strb;
  assign rd_data     = axi.rdata;
  assign rd_last     = axi.rlast;

  assign done           = done_q;
  assign done_resp      = resp_q;
  assign done_timeout   = timeout_q;
  assign done_proto_err = perr_q;
  assign state_dbg      = state;

  // State register
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (cmd_hs) state_nxt = cmd_write ? S_AW : S_AR;
      S_AW:   if (axi.awready) state_nxt = S_W;
      S_W:    if (w_hs && axi.wlast) state_nxt = S_B;
      S_B:    if (axi.bvalid || idle_expired) state_nxt = S_IDLE;
      S_AR:   if (axi.arready) state_nxt = S_R;
      S_R:    if ((r_hs && axi.rlast) || (!r_hs && idle_expired)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic. cmd_ready stays low during the done cycle, so the next
  // command is taken no earlier than the cycle after done.
  always_comb begin
    cmd_ready   = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    wr_ready    = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    rd_valid    = 1'b0;
    unique case (state)
      S_IDLE: cmd_ready = !done_q;
      S_AW:   axi.awvalid = 1'b1;
      S_W: begin
        axi.wvalid = wr_valid;
        wr_ready   = axi.wready;
        axi.wlast  = (beat_cnt == len_q);
      end
      S_B:    axi.bready = 1'b1;
      S_AR:   axi.arvalid = 1'b1;
      S_R: begin
        axi.rready = rd_ready;
        rd_valid   = axi.rvalid;
      end
      default: ;
    endcase
  end

  // Command capture, beat/idle counters and completion status
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
      resp_q    <= 2'b00;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: if (cmd_hs) begin
          addr_q    <= cmd_addr;
          len_q     <= cmd_len;
          id_q      <= cmd_id;
          beat_cnt  <= '0;
          idle_cnt  <= '0;
          timeout_q <= 1'b0;
          perr_q    <= 1'b0;
          resp_q    <= 2'b00;
        end
        S_W: if (w_hs) beat_cnt <= axi.wlast ? 4'd0 : beat_cnt + 4'd1;
        S_B: begin
          if (axi.bvalid) begin
            done_q   <= 1'b1;
            resp_q   <= axi.bresp;
            perr_q   <= (axi.bid != id_q);
            idle_cnt <= '0;
          end else if (idle_expired) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            resp_q    <= 2'b10;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_R: begin
          if (r_hs) begin
            idle_cnt <= '0;
            beat_cnt <= axi.rlast ? 4'd0 : beat_cnt + 4'd1;
            perr_q   <= perr_q | r_beat_err;
            // Keep the first error response seen in the burst.
            if (resp_q == 2'b00 && axi.rresp != 2'b00) resp_q <= axi.rresp;
            if (axi.rlast) done_q <= 1'b1;
          end else if (idle_expired) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            resp_q    <= 2'b10;
            idle_cnt  <= '0;
            beat_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_master_engine.sv
module tb_axi_master_engine;
  // ---------------- clock / reset ----------------
  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  always #5 aclk = ~aclk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0, cmd_id = '0;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        rd_valid, rd_ready = 0, rd_last;
  logic [31:0] rd_data;
  logic        done, done_timeout, done_proto_err;
  logic [1:0]  done_resp;
  logic [2:0]  state_dbg;

  axi_master_engine_if axi_bus();

  axi_master_engine #(.TIMEOUT(16)) dut (
    .aclk(aclk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_timeout(done_timeout),
    .done_proto_err(done_proto_err), .state_dbg(state_dbg),
    .axi(axi_bus)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  // ---------------- driver tasks ----------------
  task automatic slave_idle();
    axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 0; axi_bus.bid = 0;
    axi_bus.bresp = 0; axi_bus.arready = 0; axi_bus.rvalid = 0; axi_bus.rid = 0;
    axi_bus.rdata = 0; axi_bus.rresp = 0; axi_bus.rlast = 0;
  endtask

  // Returns at the falling edge after the command was accepted.
  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [3:0] l,
                           input logic [3:0] id);
    int n = 0;
    @(negedge aclk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
    #1;
    while (!cmd_ready && n < 50) begin @(negedge aclk); #1; n++; end
    n_total++; if (n >= 50) $display("FAIL cmd_accept_bound got %0d exp <50", n); else n_pass++;
    @(negedge aclk);
    cmd_valid = 0;
  endtask

  task automatic addr_accept(input logic is_write);
    if (is_write) axi_bus.awready = 1; else axi_bus.arready = 1;
    @(negedge aclk);
    axi_bus.awready = 0; axi_bus.arready = 0;
  endtask

  task automatic drive_w_burst(input int beats);
    int k = 0;
    int n = 0;
    axi_bus.wready = 1; wr_valid = 1; wr_strb = 4'hF;
    while (k < beats && n < 40) begin
      wr_data = 32'h5500_0000 + k;
      #1;
      if (axi_bus.wvalid && axi_bus.wready) k++;
      @(negedge aclk); n++;
    end
    wr_valid = 0; axi_bus.wready = 0;
    n_total++; if (k != beats) $display("FAIL w_burst_bound got %0d exp %0d", k, beats); else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst = 0;
    repeat (3) @(negedge aclk);
    #1;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL rst_state got %0d exp 0", state_dbg); else n_pass++;
    n_total++; if ({done, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid, axi_bus.rready, rd_valid} !== 7'b0)
      $display("FAIL rst_valids got %b exp 0000000", {done, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid, axi_bus.rready, rd_valid}); else n_pass++;
    n_total++; if ({done_resp, done_timeout, done_proto_err} !== 4'b0) $display("FAIL rst_status got %b exp 0000", {done_resp, done_timeout, done_proto_err}); else n_pass++;
    @(negedge aclk);
    arst = 1;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_write();
    int k = 0;
    int n = 0;
    int nlast = 0;
    logic [31:0] e;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000_0000 + i);
    wr_valid = 1; wr_data = 32'hDEAD_BEEF; wr_strb = 4'hF;  // offered early on purpose
    issue_cmd(1'b1, 32'h1000, 4'd3, 4'd5);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_total++; if (axi_bus.awvalid !== 1'b1) $display("FAIL wr_awvalid got %b exp 1", axi_bus.awvalid); else n_pass++;
      n_total++; if ({axi_bus.awaddr, axi_bus.awlen, axi_bus.awid} !== {32'h1000, 4'd3, 4'd5})
        $display("FAIL wr_aw_payload got %h/%h/%h exp 1000/3/5", axi_bus.awaddr, axi_bus.awlen, axi_bus.awid); else n_pass++;
      n_total++; if (axi_bus.wvalid !== 1'b0) $display("FAIL wr_wvalid_before_aw got %b exp 0", axi_bus.wvalid); else n_pass++;
      @(negedge aclk);
    end
    #1;
    n_total++; if ({axi_bus.awsize, axi_bus.awburst, axi_bus.awlock, axi_bus.awcache, axi_bus.awprot} !== {3'b010, 2'b01, 9'b0})
      $display("FAIL wr_aw_attr got %b/%b exp 010/01", axi_bus.awsize, axi_bus.awburst); else n_pass++;
    addr_accept(1'b1);
    #1;
    n_total++; if (axi_bus.awvalid !== 1'b0) $display("FAIL wr_awvalid_after_hs got %b exp 0", axi_bus.awvalid); else n_pass++;
    n_total++; if (state_dbg !== 3'd2) $display("FAIL wr_state_w got %0d exp 2", state_dbg); else n_pass++;
    axi_bus.wready = 1;
    while (k < 4 && n < 30) begin
      wr_valid = (n != 1);                       // one source bubble
      wr_data = 32'hA000_0000 + k; wr_strb = 4'(15 - k);
      #1;
      n_total++; if (axi_bus.wvalid !== wr_valid) $display("FAIL wr_wvalid_pass got %b exp %b", axi_bus.wvalid, wr_valid); else n_pass++;
      if (axi_bus.wvalid && axi_bus.wready) begin
        e = exp_q.pop_front();
        n_total++; if (axi_bus.wdata !== e) $display("FAIL wr_wdata got %h exp %h", axi_bus.wdata, e); else n_pass++;
        n_total++; if (axi_bus.wstrb !== 4'(15 - k)) $display("FAIL wr_wstrb got %h exp %h", axi_bus.wstrb, 4'(15 - k)); else n_pass++;
        n_total++; if (axi_bus.wlast !== (k == 3)) $display("FAIL wr_wlast got %b exp %b", axi_bus.wlast, (k == 3)); else n_pass++;
        n_total++; if (axi_bus.wid !== 4'd5) $display("FAIL wr_wid got %h exp 5", axi_bus.wid); else n_pass++;
        if (axi_bus.wlast) nlast++;
        k++;
      end
      @(negedge aclk); n++;
    end
    wr_valid = 0; axi_bus.wready = 0;
    #1;
    n_total++; if (k != 4 || nlast != 1) $display("FAIL wr_beats got %0d beats %0d wlast exp 4 1", k, nlast); else n_pass++;
    n_total++; if (axi_bus.bready !== 1'b1) $display("FAIL wr_bready got %b exp 1", axi_bus.bready); else n_pass++;
    n_total++; if (axi_bus.wvalid !== 1'b0) $display("FAIL wr_wvalid_in_b got %b exp 0", axi_bus.wvalid); else n_pass++;
    axi_bus.bvalid = 1; axi_bus.bresp = 2'b00; axi_bus.bid = 4'd5;
    @(negedge aclk);
    axi_bus.bvalid = 0;
    #1;
    n_total++; if ({done, done_resp, done_timeout, done_proto_err} !== 5'b1_00_0_0)
      $display("FAIL wr_done got %b exp 10000", {done, done_resp, done_timeout, done_proto_err}); else n_pass++;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL wr_cmd_ready_during_done got %b exp 0", cmd_ready); else n_pass++;
    @(negedge aclk); #1;
    n_total++; if ({done, cmd_ready} !== 2'b01) $display("FAIL wr_after_done got %b exp 01", {done, cmd_ready}); else n_pass++;
  endtask

  task automatic test_read_single();
    issue_cmd(1'b0, 32'h2000, 4'd0, 4'd3);
    #1;
    n_total++; if ({axi_bus.arvalid, axi_bus.araddr, axi_bus.arlen, axi_bus.arid} !== {1'b1, 32'h2000, 4'd0, 4'd3})
      $display("FAIL rd1_ar got %b/%h/%h/%h exp 1/2000/0/3", axi_bus.arvalid, axi_bus.araddr, axi_bus.arlen, axi_bus.arid); else n_pass++;
    n_total++; if ({done_timeout, done_resp} !== 3'b0) $display("FAIL rd1_status_cleared got %b exp 000", {done_timeout, done_resp}); else n_pass++;
    addr_accept(1'b0);
    rd_ready = 1;
    axi_bus.rvalid = 1; axi_bus.rdata = 32'h1234_5678; axi_bus.rresp = 2'b10; axi_bus.rlast = 1; axi_bus.rid = 4'd3;
    #1;
    n_total++; if ({rd_valid, rd_last, axi_bus.rready} !== 3'b111) $display("FAIL rd1_beat_flags got %b exp 111", {rd_valid, rd_last, axi_bus.rready}); else n_pass++;
    n_total++; if (rd_data !== 32'h1234_5678) $display("FAIL rd1_data got %h exp 12345678", rd_data); else n_pass++;
    @(negedge aclk);
    axi_bus.rvalid = 0; axi_bus.rlast = 0; rd_ready = 0;
    #1;
    n_total++; if ({done, done_resp, done_proto_err} !== 4'b1_10_0) $display("FAIL rd1_done got %b exp 1100", {done, done_resp, done_proto_err}); else n_pass++;
    @(negedge aclk);
  endtask

  task automatic test_read_burst();
    logic [31:0] rdat [4];
    logic [31:0] e;
    int k = 0;
    int n = 0;
    int got = 0;
    rdat[0] = 32'h1111_0000; rdat[1] = 32'h2222_0001; rdat[2] = 32'h3333_0002; rdat[3] = 32'h4444_0003;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(rdat[i]);
    issue_cmd(1'b0, 32'h3000, 4'd3, 4'd7);
    addr_accept(1'b0);
    while (k < 4 && n < 40) begin
      axi_bus.rvalid = 1; axi_bus.rdata = rdat[k]; axi_bus.rid = 4'd7; axi_bus.rlast = (k == 3);
      axi_bus.rresp = (k == 1) ? 2'b11 : (k == 2) ? 2'b10 : 2'b00;
      rd_ready = (n % 2 == 1);
      #1;
      n_total++; if (axi_bus.rready !== rd_ready) $display("FAIL rdb_rready got %b exp %b", axi_bus.rready, rd_ready); else n_pass++;
      if (rd_valid && rd_ready) begin
        e = exp_q.pop_front();
        n_total++; if (rd_data !== e) $display("FAIL rdb_data got %h exp %h", rd_data, e); else n_pass++;
        n_total++; if (rd_last !== (got == 3)) $display("FAIL rdb_last got %b exp %b", rd_last, (got == 3)); else n_pass++;
        got++;
      end
      if (axi_bus.rvalid && axi_bus.rready) k++;
      @(negedge aclk); n++;
    end
    axi_bus.rvalid = 0; axi_bus.rlast = 0; rd_ready = 0;
    #1;
    n_total++; if (got != 4) $display("FAIL rdb_beats got %0d exp 4", got); else n_pass++;
    n_total++; if ({done, done_resp, done_proto_err} !== 4'b1_11_0) $display("FAIL rdb_done got %b exp 1110", {done, done_resp, done_proto_err}); else n_pass++;
    @(negedge aclk);
  endtask

  task automatic test_proto_err();
    int k = 0;
    int n = 0;
    // Read of 4 beats that ends early on beat 2
    issue_cmd(1'b0, 32'h3400, 4'd3, 4'd2);
    addr_accept(1'b0);
    rd_ready = 1;
    while (k < 2 && n < 20) begin
      axi_bus.rvalid = 1; axi_bus.rdata = 32'hC0DE_0000 + k; axi_bus.rid = 4'd2;
      axi_bus.rresp = 2'b00; axi_bus.rlast = (k == 1);
      #1;
      if (axi_bus.rvalid && axi_bus.rready) k++;
      @(negedge aclk); n++;
    end
    axi_bus.rvalid = 0; axi_bus.rlast = 0; rd_ready = 0;
    #1;
    n_total++; if ({done, done_resp, done_proto_err} !== 4'b1_00_1) $display("FAIL perr_rd_done got %b exp 1001", {done, done_resp, done_proto_err}); else n_pass++;
    @(negedge aclk);
    // Write whose B response carries the wrong id
    issue_cmd(1'b1, 32'h5000, 4'd0, 4'd5);
    addr_accept(1'b1);
    drive_w_burst(1);
    axi_bus.bvalid = 1; axi_bus.bresp = 2'b00; axi_bus.bid = 4'd6;
    @(negedge aclk);
    axi_bus.bvalid = 0; axi_bus.bid = 0;
    #1;
    n_total++; if ({done, done_resp, done_proto_err} !== 4'b1_00_1) $display("FAIL perr_bid_done got %b exp 1001", {done, done_resp, done_proto_err}); else n_pass++;
    @(negedge aclk);
  endtask

  task automatic test_timeout();
    int n = 0;
    issue_cmd(1'b1, 32'h6000, 4'd1, 4'd1);
    addr_accept(1'b1);
    drive_w_burst(2);
    #1;
    n_total++; if (axi_bus.bready !== 1'b1) $display("FAIL to_bready got %b exp 1", axi_bus.bready); else n_pass++;
    // Now in the first cycle of B; bvalid is never given.
    while (!done && n < 40) begin @(negedge aclk); #1; n++; end
    n_total++; if (n != 16) $display("FAIL to_latency got %0d exp 16", n); else n_pass++;
    n_total++; if ({done, done_resp, done_timeout, done_proto_err} !== 5'b1_10_1_0)
      $display("FAIL to_status got %b exp 11010", {done, done_resp, done_timeout, done_proto_err}); else n_pass++;
    @(negedge aclk); #1;
    n_total++; if ({axi_bus.bready, cmd_ready} !== 2'b01) $display("FAIL to_after got %b exp 01", {axi_bus.bready, cmd_ready}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    issue_cmd(1'b1, 32'h7000, 4'd3, 4'd4);
    addr_accept(1'b1);
    wr_valid = 1; wr_data = 32'h0BAD_0000; wr_strb = 4'hF; axi_bus.wready = 1;
    @(negedge aclk);                              // one beat taken, still in W
    arst = 0;
    #1;
    n_total++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid, axi_bus.rready, rd_valid} !== 6'b0)
      $display("FAIL rstm_valids got %b exp 000000", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid, axi_bus.rready, rd_valid}); else n_pass++;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL rstm_state got %0d exp 0", state_dbg); else n_pass++;
    repeat (2) begin @(negedge aclk); #1; if (done) seen_done++; end
    arst = 1; wr_valid = 0; axi_bus.wready = 0;
    repeat (3) begin @(negedge aclk); #1; if (done) seen_done++; end
    n_total++; if (seen_done != 0) $display("FAIL rstm_no_done got %0d exp 0", seen_done); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rstm_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    slave_idle();
    test_reset();
    test_write();
    test_read_single();
    test_read_burst();
    test_proto_err();
    test_timeout();
    test_read_single();      // also checks status is cleared after the timeout
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
